// File: rtl/gates_mon_pkg.sv
// Shared types and constants for gates_edge_monitor.
// GATES_MON_FALL_EN widens the overflow vector to make room for the falling-edge channels.
package gates_mon_pkg;

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam int DEF_CNT_W = 8;

`ifdef GATES_MON_FALL_EN
    localparam int OVF_W = 4;
`else
    localparam int OVF_W = 2;
`endif

    function automatic int unsigned sat_val(input int unsigned w);
        return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/gates_edge_ctr.sv
// One channel: saturating edge counter with a sticky overflow flag.
// clear_i starts a new window, and an edge in that same cycle already counts as 1.
module gates_edge_ctr
    import gates_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             edge_i,
    input  logic             clear_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] SAT = CNT_W'(sat_val(CNT_W));

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear_i) begin
            cnt_d = edge_i ? CNT_W'(1) : '0;
            ovf_d = 1'b0;
        end else if (edge_i) begin
            // A full counter holds its value, and the flag records the lost edge.
            if (cnt_q == SAT) begin
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/gates_edge_monitor.sv
// Counts rising edges on the two gates outputs and hands out windowed snapshots over valid/ready.
// Defining GATES_MON_FALL_EN adds falling-edge counters and the snap_fall_1/snap_fall_2 ports.
module gates_edge_monitor
    import gates_mon_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_1,
    input  logic             in_2,
    input  logic             snap_req,
    input  logic             snap_ready,
    output logic             snap_valid,
    output logic [CNT_W-1:0] snap_cnt_1,
    output logic [CNT_W-1:0] snap_cnt_2,
`ifdef GATES_MON_FALL_EN
    output logic [CNT_W-1:0] snap_fall_1,
    output logic [CNT_W-1:0] snap_fall_2,
`endif
    output logic [OVF_W-1:0] snap_ovf,
    output logic [1:0]       level
);

    logic [1:0]       in_r_q;
    logic             armed_q;
    state_t           state_q;
    logic             snap_valid_q;
    logic [CNT_W-1:0] snap_cnt_1_q, snap_cnt_2_q;
    logic [OVF_W-1:0] snap_ovf_q;
    logic [1:0]       rise;
    logic             capture;
    logic [CNT_W-1:0] live_rise_1, live_rise_2;
    logic             ovf_rise_1, ovf_rise_2;

    // armed_q masks the first cycle after reset, so an input that is already high does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_r_q  <= '0;
            armed_q <= 1'b0;
        end else begin
            in_r_q  <= {in_2, in_1};
            armed_q <= 1'b1;
        end
    end

    assign rise    = {in_2, in_1} & ~in_r_q & {2{armed_q}};
    assign capture = (state_q == IDLE) && snap_req;

    gates_edge_ctr #(.CNT_W(CNT_W)) u_rise_1 (
        .clk(clk), .rst(rst), .edge_i(rise[0]), .clear_i(capture),
        .cnt_o(live_rise_1), .ovf_o(ovf_rise_1)
    );

    gates_edge_ctr #(.CNT_W(CNT_W)) u_rise_2 (
        .clk(clk), .rst(rst), .edge_i(rise[1]), .clear_i(capture),
        .cnt_o(live_rise_2), .ovf_o(ovf_rise_2)
    );

`ifdef GATES_MON_FALL_EN
    logic [1:0]       fall;
    logic [CNT_W-1:0] live_fall_1, live_fall_2;
    logic             ovf_fall_1, ovf_fall_2;
    logic [CNT_W-1:0] snap_fall_1_q, snap_fall_2_q;

    assign fall = ~{in_2, in_1} & in_r_q & {2{armed_q}};

    gates_edge_ctr #(.CNT_W(CNT_W)) u_fall_1 (
        .clk(clk), .rst(rst), .edge_i(fall[0]), .clear_i(capture),
        .cnt_o(live_fall_1), .ovf_o(ovf_fall_1)
    );

    gates_edge_ctr #(.CNT_W(CNT_W)) u_fall_2 (
        .clk(clk), .rst(rst), .edge_i(fall[1]), .clear_i(capture),
        .cnt_o(live_fall_2), .ovf_o(ovf_fall_2)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            snap_fall_1_q <= '0;
            snap_fall_2_q <= '0;
        end else if (capture) begin
            snap_fall_1_q <= live_fall_1;
            snap_fall_2_q <= live_fall_2;
        end
    end

    assign snap_fall_1 = snap_fall_1_q;
    assign snap_fall_2 = snap_fall_2_q;
`endif

    // Capture takes the live counts from before this edge; the counters clear on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_valid_q <= 1'b0;
            snap_cnt_1_q <= '0;
            snap_cnt_2_q <= '0;
            snap_ovf_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (snap_req) begin
                        state_q      <= HOLD;
                        snap_valid_q <= 1'b1;
                        snap_cnt_1_q <= live_rise_1;
                        snap_cnt_2_q <= live_rise_2;
`ifdef GATES_MON_FALL_EN
                        snap_ovf_q   <= {ovf_fall_2, ovf_fall_1, ovf_rise_2, ovf_rise_1};
`else
                        snap_ovf_q   <= {ovf_rise_2, ovf_rise_1};
`endif
                    end
                end
                HOLD: begin
                    if (snap_ready) begin
                        state_q      <= IDLE;
                        snap_valid_q <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign snap_valid = snap_valid_q;
    assign snap_cnt_1 = snap_cnt_1_q;
    assign snap_cnt_2 = snap_cnt_2_q;
    assign snap_ovf   = snap_ovf_q;
    assign level      = in_r_q;

endmodule
